pulse_cfg_loader: RTL and testbench
===================================

Name: pulse_cfg_loader

Overview:
- Upstream configuration stage for the TTL pulse generator.
- Assembles 32-bit width, 32-bit period and 16-bit count from byte-wide writes on slow, asynchronous chip pins.
- Validates the assembled shadow set and commits it atomically to the generator's parameter inputs.
- On each valid commit, issues a restart reset to the generator so the new parameters take effect from a clean start.

Parameters:
- SYNC_STAGES, 2, flops in the strobe synchronizer (min 2).
- GEN_RST_CYCLES, 4, cycles gen_rst_n is held low after a valid commit (min 1, max 255).
- DEFAULT_WIDTH, 32'd10, reset value of shadow and active width.
- DEFAULT_PERIOD, 32'd100, reset value of shadow and active period.
- DEFAULT_COUNT, 16'd1, reset value of shadow and active count.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_strobe  input  1  asynchronous write strobe; a rising edge requests one write
- addr  input  4  register address; stable while wr_strobe is high
- wdata  input  8  write data; stable while wr_strobe is high
- pulse_width  output  32  active width, to generator
- pulse_period  output  32  active period, to generator
- pulse_count  output  16  active pulse count, to generator
- gen_rst_n  output  1  active-low generator restart
- cfg_valid  output  1  high once any valid commit has occurred
- cfg_error  output  1  sticky flag: last commit rejected
- rdata  output  8  readback; present only with the optional feature

Behaviour:
- Reset (async, rst_n low):
  - Shadow and active registers load the DEFAULT_* values.
  - cfg_valid=0, cfg_error=0.
  - gen_rst_n=0, with hold counter=GEN_RST_CYCLES; after rst_n deasserts, gen_rst_n rises once the hold counter expires.
  - Synchronizer flops clear to 0.
- Strobe path:
  - wr_strobe passes through a SYNC_STAGES-flop synchronizer, then a rising-edge detector.
  - The detector produces a one-cycle wr_evt. With SYNC_STAGES=2, wr_evt is high in the 3rd cycle after the first clk edge that samples wr_strobe high.
  - addr and wdata are sampled, unsynchronized, in the wr_evt cycle. Protocol requires them stable from strobe rise to strobe fall.
  - A level held high produces exactly one event. A strobe shorter than one clock may be missed; this is permitted.
- Register map (shadow registers, little-endian bytes):
  - 0x0-0x3: width bytes 0-3.
  - 0x4-0x7: period bytes 0-3.
  - 0x8-0x9: count bytes 0-1.
  - 0xA: control. wdata[0]=commit, wdata[1]=clear_error. Both bits may be set together; commit takes precedence for cfg_error.
  - 0xB-0xF: writes ignored; no state change.
- Commit (wr_evt at 0xA with wdata[0]=1) validates the shadow set: width>=1, period>width, count>=1.
  - Valid: the next clk edge copies all shadow values to active together (no partial update is ever visible). On the same edge: cfg_valid=1, cfg_error=0, gen_rst_n=0, hold counter=GEN_RST_CYCLES. gen_rst_n returns to 1 after exactly GEN_RST_CYCLES cycles low.
  - Invalid: active registers and gen_rst_n unchanged; cfg_error=1 on the next edge. cfg_valid keeps its previous value.
  - Shadow registers are never modified by a commit.
- Clear error: wr_evt at 0xA with wdata[1]=1 and wdata[0]=0 sets cfg_error=0.
- Control FSM states:
  - IDLE: gen_rst_n=1.
  - HOLD: gen_rst_n=0, hold counter decrements; moves to IDLE when it reaches 1.
  - A valid commit during HOLD reloads the counter and extends the hold.
  - Shadow writes during HOLD are accepted and do not affect active registers.
- Arithmetic: no wrap. Full 32-bit unsigned compares; period=32'hFFFFFFFF with width=32'hFFFFFFFE is valid.
- Reset mid-operation: async reset clears everything to reset values regardless of FSM state; any pending event is lost.

Optional Feature:
- Macro: PULSE_CFG_READBACK_EN.
- Defined: the rdata port exists and combinationally returns the shadow byte selected by addr. At 0xA it returns {6'b0, cfg_error, cfg_valid}; at 0xB-0xF it returns 8'h00.
- Undefined: no rdata port and no readback mux; all other behaviour identical.

Decomposition:
- Shared package pulse_cfg_pkg holds:
  - Address constants ADDR_WIDTH0..ADDR_CTRL.
  - Control bit indices CTRL_COMMIT=0, CTRL_CLR_ERR=1.
  - Width constants W_WIDTH=32, W_PERIOD=32, W_COUNT=16.
  - FSM state typedef {IDLE, HOLD}.
- One sub-module: sync_rise_detect (parameter SYNC_STAGES), containing the synchronizer and edge detector and producing wr_evt. It is reused for future pin inputs.

Test Plan:
- Reset release -> outputs 10/100/1, cfg_valid=0, cfg_error=0; gen_rst_n low for 4 cycles after rst_n rises, then 1.
- Write width=0x00000005 and period=0x00000014 bytewise, count=0x0003, commit -> active=5/20/3 on the edge after the commit event; gen_rst_n low exactly 4 cycles; cfg_valid=1.
- Write width=20 and period=20, commit -> active unchanged, cfg_error=1, gen_rst_n stays 1. Then write 0xA with 0x02 -> cfg_error=0.
- Write to 0xC with wdata=0xFF, and hold wr_strobe high for 50 cycles -> exactly one wr_evt; no register change.
- Issue two valid commits 2 cycles apart (events) -> gen_rst_n low continuously for 2+4 cycles; active holds the second set.
- Pull rst_n low mid-HOLD after a commit of 5/20/3 -> immediate return to defaults 10/100/1 and gen_rst_n=0. With PULSE_CFG_READBACK_EN, after reset, addr=0x4 -> rdata=8'h64.

Source files
------------

// File: rtl/pulse_cfg_pkg.sv
// Shared constants, types and the shadow-set validity rule for the pulse generator config loader.
package pulse_cfg_pkg;

  localparam int W_WIDTH  = 32;
  localparam int W_PERIOD = 32;
  localparam int W_COUNT  = 16;

  localparam logic [3:0] ADDR_WIDTH0  = 4'h0;
  localparam logic [3:0] ADDR_WIDTH1  = 4'h1;
  localparam logic [3:0] ADDR_WIDTH2  = 4'h2;
  localparam logic [3:0] ADDR_WIDTH3  = 4'h3;
  localparam logic [3:0] ADDR_PERIOD0 = 4'h4;
  localparam logic [3:0] ADDR_PERIOD1 = 4'h5;
  localparam logic [3:0] ADDR_PERIOD2 = 4'h6;
  localparam logic [3:0] ADDR_PERIOD3 = 4'h7;
  localparam logic [3:0] ADDR_COUNT0  = 4'h8;
  localparam logic [3:0] ADDR_COUNT1  = 4'h9;
  localparam logic [3:0] ADDR_CTRL    = 4'hA;

  localparam int N_SHADOW_BYTES = 10;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_CLR_ERR = 1;

  typedef enum logic {IDLE, HOLD} cfg_state_t;

  typedef struct packed {
    logic [W_WIDTH-1:0]  width;
    logic [W_PERIOD-1:0] period;
    logic [W_COUNT-1:0]  count;
  } pulse_cfg_t;

  // A set is usable only if at least one pulse of non-zero width fits inside the period.
  function automatic logic cfg_is_valid(input pulse_cfg_t cfg);
    return (cfg.width != '0) && (cfg.period > cfg.width) && (cfg.count != '0);
  endfunction

endpackage

// File: rtl/pulse_cfg_loader_if.sv
// Byte-wide pin bus into the config loader; rdata exists only when PULSE_CFG_READBACK_EN is defined.
interface pulse_cfg_loader_if;
  logic       wr_strobe;
  logic [3:0] addr;
  logic [7:0] wdata;
`ifdef PULSE_CFG_READBACK_EN
  logic [7:0] rdata;

  modport master (output wr_strobe, output addr, output wdata, input  rdata);
  modport slave  (input  wr_strobe, input  addr, input  wdata, output rdata);
`else
  modport master (output wr_strobe, output addr, output wdata);
  modport slave  (input  wr_strobe, input  addr, input  wdata);
`endif
endinterface

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous pin followed by a registered rising-edge detector.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   evt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      evt_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      evt_reg  <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign evt = evt_reg;

endmodule

// File: rtl/pulse_cfg_loader.sv
// Assembles, validates and atomically commits pulse generator parameters, then restarts the generator.
// Optional readback mux on the bus is enabled by PULSE_CFG_READBACK_EN.
module pulse_cfg_loader
  import pulse_cfg_pkg::*;
#(
  parameter int                  SYNC_STAGES    = 2,
  parameter int                  GEN_RST_CYCLES = 4,
  parameter logic [W_WIDTH-1:0]  DEFAULT_WIDTH  = 32'd10,
  parameter logic [W_PERIOD-1:0] DEFAULT_PERIOD = 32'd100,
  parameter logic [W_COUNT-1:0]  DEFAULT_COUNT  = 16'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_cfg_loader_if.slave    bus,
  output logic [W_WIDTH-1:0]   pulse_width,
  output logic [W_PERIOD-1:0]  pulse_period,
  output logic [W_COUNT-1:0]   pulse_count,
  output logic                 gen_rst_n,
  output logic                 cfg_valid,
  output logic                 cfg_error
);

  localparam logic [8*N_SHADOW_BYTES-1:0] DEFAULT_SHADOW = {DEFAULT_COUNT, DEFAULT_PERIOD, DEFAULT_WIDTH};
  localparam logic [7:0]                  HOLD_LOAD      = 8'(GEN_RST_CYCLES);
  localparam pulse_cfg_t                  DEFAULT_CFG    = '{width: DEFAULT_WIDTH, period: DEFAULT_PERIOD, count: DEFAULT_COUNT};

  logic                          wr_evt;
  logic [7:0]                    shadow_reg [N_SHADOW_BYTES];
  logic [N_SHADOW_BYTES-1:0]     byte_we;
  logic [8*N_SHADOW_BYTES-1:0]   shadow_flat;
  pulse_cfg_t                    shadow_cfg;
  pulse_cfg_t                    active_reg;
  logic                          cfg_valid_reg;
  logic                          cfg_error_reg;
  logic                          ctrl_hit;
  logic                          commit_req;
  logic                          commit_ok;
  logic                          clr_req;
  cfg_state_t                    state_reg, state_next;
  logic [7:0]                    hold_cnt_reg, hold_cnt_next;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.wr_strobe),
    .evt      (wr_evt)
  );

  // addr/wdata are held stable by the pin protocol, so they are used directly in the event cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_SHADOW_BYTES; gi++) begin : g_shadow
      assign byte_we[gi]               = wr_evt && (bus.addr == 4'(gi));
      assign shadow_flat[gi*8 +: 8]    = shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SHADOW_BYTES; i++) begin
        shadow_reg[i] <= DEFAULT_SHADOW[i*8 +: 8];
      end
    end else begin
      for (int i = 0; i < N_SHADOW_BYTES; i++) begin
        if (byte_we[i]) begin
          shadow_reg[i] <= bus.wdata;
        end
      end
    end
  end

  assign shadow_cfg.width  = shadow_flat[31:0];
  assign shadow_cfg.period = shadow_flat[63:32];
  assign shadow_cfg.count  = shadow_flat[79:64];

  assign ctrl_hit   = wr_evt && (bus.addr == ADDR_CTRL);
  assign commit_req = ctrl_hit && bus.wdata[CTRL_COMMIT];
  assign commit_ok  = commit_req && cfg_is_valid(shadow_cfg);
  assign clr_req    = ctrl_hit && bus.wdata[CTRL_CLR_ERR] && !bus.wdata[CTRL_COMMIT];

  // The whole set moves in one edge so the generator never sees a mix of old and new fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg    <= DEFAULT_CFG;
      cfg_valid_reg <= 1'b0;
      cfg_error_reg <= 1'b0;
    end else begin
      if (commit_ok) begin
        active_reg    <= shadow_cfg;
        cfg_valid_reg <= 1'b1;
      end
      if (commit_req) begin
        cfg_error_reg <= !commit_ok;
      end else if (clr_req) begin
        cfg_error_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= HOLD_LOAD;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    if (commit_ok) begin
      state_next    = HOLD;
      hold_cnt_next = HOLD_LOAD;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        HOLD: begin
          if (hold_cnt_reg <= 8'd1) begin
            state_next = IDLE;
          end else begin
            hold_cnt_next = hold_cnt_reg - 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    gen_rst_n = 1'b1;
    if (state_reg == HOLD) begin
      gen_rst_n = 1'b0;
    end
  end

  assign pulse_width  = active_reg.width;
  assign pulse_period = active_reg.period;
  assign pulse_count  = active_reg.count;
  assign cfg_valid    = cfg_valid_reg;
  assign cfg_error    = cfg_error_reg;

`ifdef PULSE_CFG_READBACK_EN
  always_comb begin
    bus.rdata = 8'h00;
    for (int i = 0; i < N_SHADOW_BYTES; i++) begin
      if (bus.addr == 4'(i)) begin
        bus.rdata = shadow_reg[i];
      end
    end
    if (bus.addr == ADDR_CTRL) begin
      bus.rdata = {6'b0, cfg_error_reg, cfg_valid_reg};
    end
  end
`endif

endmodule

// File: tb/tb_pulse_cfg_loader.sv
// Directed plus randomized bench for pulse_cfg_loader against a register-map level reference model.
module tb_pulse_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pulse_width;
  logic [31:0] pulse_period;
  logic [15:0] pulse_count;
  logic        gen_rst_n;
  logic        cfg_valid;
  logic        cfg_error;

  int checks = 0;
  int failures = 0;

  // Reference model: shadow bytes by address, active set and flags.
  logic [7:0]  sh [0:9];
  logic [31:0] m_w, m_p;
  logic [15:0] m_c;
  logic        m_valid, m_err;

  logic [31:0] pw_s [0:127];
  logic        gen_s [0:127];
  int          gen_low;

  pulse_cfg_loader_if bus ();

  pulse_cfg_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .pulse_width  (pulse_width),
    .pulse_period (pulse_period),
    .pulse_count  (pulse_count),
    .gen_rst_n    (gen_rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_error    (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 32'd10; m_p = 32'd100; m_c = 16'd1;
    m_valid = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) sh[i] = m_w[i*8 +: 8];
    for (int i = 0; i < 4; i++) sh[4+i] = m_p[i*8 +: 8];
    for (int i = 0; i < 2; i++) sh[8+i] = m_c[i*8 +: 8];
  endtask

  // Returns how many cycles gen_rst_n is expected low because of this write.
  function automatic int model_write(input logic [3:0] a, input logic [7:0] d);
    logic [31:0] w, p;
    logic [15:0] c;
    if (a < 4'd10) begin
      sh[a] = d;
    end else if (a == 4'd10) begin
      if (d[0]) begin
        w = {sh[3], sh[2], sh[1], sh[0]};
        p = {sh[7], sh[6], sh[5], sh[4]};
        c = {sh[9], sh[8]};
        if (w >= 1 && p > w && c >= 1) begin
          m_w = w; m_p = p; m_c = c;
          m_valid = 1'b1; m_err = 1'b0;
          return 4;
        end
        m_err = 1'b1;
      end else if (d[1]) begin
        m_err = 1'b0;
      end
    end
    return 0;
  endfunction

  function automatic logic [7:0] model_rdata(input logic [3:0] a);
    if (a < 4'd10) return sh[a];
    if (a == 4'd10) return {6'b0, m_err, m_valid};
    return 8'h00;
  endfunction

  // Strobe high for hi cycles, then low long enough for any restart hold to finish.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int hi);
    @(negedge clk);
    bus.addr = a;
    bus.wdata = d;
    bus.wr_strobe = 1'b1;
    gen_low = 0;
    for (int i = 0; i < hi + 10; i++) begin
      @(negedge clk);
      pw_s[i] = pulse_width;
      gen_s[i] = gen_rst_n;
      if (!gen_rst_n) gen_low++;
      if (i == hi - 1) bus.wr_strobe = 1'b0;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input int hi);
    int exp_low;
    exp_low = model_write(a, d);
    do_write(a, d, hi);
    chk($sformatf("gen_low a=%0h d=%0h", a, d), 32'(gen_low), 32'(exp_low));
  endtask

  task automatic check_state(input string tag);
    chk({tag, " width"}, pulse_width, m_w);
    chk({tag, " period"}, pulse_period, m_p);
    chk({tag, " count"}, 32'(pulse_count), 32'(m_c));
    chk({tag, " cfg_valid"}, 32'(cfg_valid), 32'(m_valid));
    chk({tag, " cfg_error"}, 32'(cfg_error), 32'(m_err));
    chk({tag, " gen_rst_n"}, 32'(gen_rst_n), 32'd1);
  endtask

  task automatic write32(input logic [3:0] base, input logic [31:0] v, input int nbytes);
    for (int i = 0; i < nbytes; i++) wr(base + 4'(i), v[i*8 +: 8], 2);
  endtask

  initial begin
    int cnt;
    int first_low, last_low;
    logic [3:0] a;
    logic [7:0] d;

    bus.wr_strobe = 1'b0;
    bus.addr = 4'h0;
    bus.wdata = 8'h00;
    model_reset();

    // Reset values and restart hold after release
    repeat (3) @(negedge clk);
    chk("rst width", pulse_width, 32'd10);
    chk("rst period", pulse_period, 32'd100);
    chk("rst count", 32'(pulse_count), 32'd1);
    chk("rst cfg_valid", 32'(cfg_valid), 32'd0);
    chk("rst cfg_error", 32'(cfg_error), 32'd0);
    chk("rst gen_rst_n", 32'(gen_rst_n), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gen_rst_n) break;
      cnt++;
    end
    chk("rst hold cycles", 32'(cnt), 32'd4);
    check_state("post-rst");

    // Basic valid commit with exact latency
    write32(4'h0, 32'h0000_0005, 4);
    write32(4'h4, 32'h0000_0014, 4);
    write32(4'h8, 32'h0000_0003, 2);
    void'(model_write(4'hA, 8'h01));
    do_write(4'hA, 8'h01, 2);
    chk("commit old before edge", pw_s[2], 32'd10);
    chk("commit new after edge", pw_s[3], 32'd5);
    chk("commit gen before", 32'(gen_s[2]), 32'd1);
    chk("commit gen first low", 32'(gen_s[3]), 32'd0);
    chk("commit gen last low", 32'(gen_s[6]), 32'd0);
    chk("commit gen released", 32'(gen_s[7]), 32'd1);
    chk("commit gen low count", 32'(gen_low), 32'd4);
    check_state("commit 5/20/3");

    // Invalid commit (period == width), then clear
    wr(4'h0, 8'h14, 2);
    wr(4'hA, 8'h01, 2);
    check_state("invalid commit");
    wr(4'hA, 8'h02, 2);
    check_state("clear error");

    // Ignored address with long strobe; long commit strobe gives one event
    wr(4'hC, 8'hFF, 50);
    check_state("ignored addr");
    wr(4'h0, 8'h05, 2);
    wr(4'hA, 8'h01, 50);
    check_state("long commit");

    // Two commits two cycles apart extend the hold
    write32(4'h0, 32'h0000_0007, 1);
    write32(4'h4, 32'h0000_0030, 1);
    write32(4'h8, 32'h0000_0002, 1);
    void'(model_write(4'hA, 8'h01));
    void'(model_write(4'hA, 8'h01));
    @(negedge clk);
    bus.addr = 4'hA;
    bus.wdata = 8'h01;
    bus.wr_strobe = 1'b1;
    cnt = 0; first_low = -1; last_low = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!gen_rst_n) begin
        cnt++;
        if (first_low < 0) first_low = i;
        last_low = i;
      end
      bus.wr_strobe = (i == 1);
    end
    chk("double commit low count", 32'(cnt), 32'd6);
    chk("double commit contiguous", 32'(last_low - first_low + 1), 32'd6);
    check_state("double commit");

    // Unsigned boundaries
    write32(4'h0, 32'hFFFF_FFFE, 4);
    write32(4'h4, 32'hFFFF_FFFF, 4);
    write32(4'h8, 32'h0000_0001, 2);
    wr(4'hA, 8'h01, 2);
    check_state("max valid");
    wr(4'h0, 8'hFF, 2);
    wr(4'hA, 8'h03, 2);
    check_state("width==period max");
    wr(4'h0, 8'h00, 2);
    wr(4'h8, 8'h00, 2);
    wr(4'hA, 8'h03, 2);
    check_state("count zero");

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 4'hA;
        d = 8'($urandom_range(0, 3));
      end else begin
        a = 4'($urandom_range(0, 15));
        d = 8'($urandom);
        if (a == 4'h9 || a == 4'h3) d = 8'($urandom_range(0, 2));
      end
      wr(a, d, $urandom_range(1, 6));
      check_state($sformatf("rand%0d", n));
`ifdef PULSE_CFG_READBACK_EN
      bus.addr = 4'($urandom_range(0, 15));
      #1 chk($sformatf("rand%0d rdata a=%0h", n, bus.addr), 32'(bus.rdata), 32'(model_rdata(bus.addr)));
`endif
    end

    // Async reset in the middle of a restart hold
    write32(4'h0, 32'h0000_0005, 4);
    write32(4'h4, 32'h0000_0014, 4);
    write32(4'h8, 32'h0000_0003, 2);
    void'(model_write(4'hA, 8'h01));
    @(negedge clk);
    bus.addr = 4'hA;
    bus.wdata = 8'h01;
    bus.wr_strobe = 1'b1;
    repeat (5) @(negedge clk);
    bus.wr_strobe = 1'b0;
    chk("midhold active width", pulse_width, 32'd5);
    chk("midhold gen low", 32'(gen_rst_n), 32'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst width", pulse_width, 32'd10);
    chk("async rst period", pulse_period, 32'd100);
    chk("async rst count", 32'(pulse_count), 32'd1);
    chk("async rst cfg_valid", 32'(cfg_valid), 32'd0);
    chk("async rst gen_rst_n", 32'(gen_rst_n), 32'd0);
`ifdef PULSE_CFG_READBACK_EN
    bus.addr = 4'h4;
    #1 chk("rdata period0 after rst", 32'(bus.rdata), 32'h64);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_state("after second reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
